// File: rtl/sad_search_ctrl.sv
// -----------------------------------------------------------------------------
// sad_search_ctrl
// Sequencer for an exhaustive template-match search. Loads a TPL x TPL template
// into an external PE array, walks every candidate window position in raster
// order, tracks the lowest SAD reported by the array, then sends the winning
// (x, y) over UART and strobes the result.
//
// Ports
//   clock, reset          sole clock (rising edge); asynchronous active-high reset
//   UARTstart             start a search (IDLE only)
//   RAMready              image RAM loaded; begins template load
//   UARTsendComplete      UART finished the current word
//   sad_in / sad_valid    SAD result from the PE array
//   threshold             early-exit limit (used when EARLY_EXIT = 1)
//   PEreset               clears the PE array (first WAIT_RAM cycle)
//   PEload / ROMtoRead    template load strobe and template ROM address
//   PEshift               advance PE window one position
//   PEmatch               request SAD of current window
//   cand_x / cand_y       candidate currently being evaluated
//   UARTsend              00 idle, 01 send x, 10 send y
//   busy                  high in every state except IDLE
//   valid                 one-cycle result strobe
//   x_out, y_out, best_sad  best match found so far / final result
// -----------------------------------------------------------------------------
module sad_search_ctrl #(
   parameter int unsigned IMG_W      = 640,
   parameter int unsigned IMG_H      = 480,
   parameter int unsigned TPL        = 8,
   parameter int unsigned SAD_W      = 16,
   parameter int unsigned X_W        = 10,
   parameter int unsigned Y_W        = 9,
   parameter int unsigned EARLY_EXIT = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           UARTstart,
   input  logic                           RAMready,
   input  logic                           UARTsendComplete,
   input  logic [SAD_W-1:0]               sad_in,
   input  logic                           sad_valid,
   input  logic [SAD_W-1:0]               threshold,
   output logic                           PEreset,
   output logic                           PEload,
   output logic                           PEshift,
   output logic                           PEmatch,
   output logic [$clog2(TPL*TPL)-1:0]     ROMtoRead,
   output logic [X_W-1:0]                 cand_x,
   output logic [Y_W-1:0]                 cand_y,
   output logic [1:0]                     UARTsend,
   output logic                           busy,
   output logic                           valid,
   output logic [X_W-1:0]                 x_out,
   output logic [Y_W-1:0]                 y_out,
   output logic [SAD_W-1:0]               best_sad
);

   localparam int unsigned ROM_AW = $clog2(TPL*TPL);

   localparam logic [X_W-1:0]    LAST_X   = X_W'(IMG_W - TPL);
   localparam logic [Y_W-1:0]    LAST_Y   = Y_W'(IMG_H - TPL);
   localparam logic [ROM_AW-1:0] LAST_ROM = ROM_AW'(TPL*TPL - 1);

   localparam logic [1:0] UART_IDLE = 2'b00;
   localparam logic [1:0] UART_X    = 2'b01;
   localparam logic [1:0] UART_Y    = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StWaitRam,
      StLoadTpl,
      StScanReq,
      StScanWait,
      StSendX,
      StSendY,
      StDone
   } state_e;

   state_e              r_state;
   logic                r_pe_reset;
   logic                r_pe_load;
   logic                r_pe_shift;
   logic                r_pe_match;
   logic [ROM_AW-1:0]   r_rom_addr;
   logic [X_W-1:0]      r_cand_x;
   logic [Y_W-1:0]      r_cand_y;
   logic [1:0]          r_uart_send;
   logic                r_busy;
   logic                r_valid;
   logic [X_W-1:0]      r_x_out;
   logic [Y_W-1:0]      r_y_out;
   logic [SAD_W-1:0]    r_best_sad;

   logic w_better;
   logic w_last;
   logic w_exit;

   // Strict less-than: on a tie the earlier (first-found) position is kept.
   assign w_better = (sad_in < r_best_sad);
   assign w_last   = (r_cand_x == LAST_X) && (r_cand_y == LAST_Y);
   assign w_exit   = (EARLY_EXIT != 0) && (sad_in <= threshold);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= StIdle;
         r_pe_reset  <= 1'b0;
         r_pe_load   <= 1'b0;
         r_pe_shift  <= 1'b0;
         r_pe_match  <= 1'b0;
         r_rom_addr  <= '0;
         r_cand_x    <= '0;
         r_cand_y    <= '0;
         r_uart_send <= UART_IDLE;
         r_busy      <= 1'b0;
         r_valid     <= 1'b0;
         r_x_out     <= '0;
         r_y_out     <= '0;
         r_best_sad  <= '1;
      end else begin
         // Single-cycle strobes default low; states raise them on entry.
         r_pe_reset <= 1'b0;
         r_pe_shift <= 1'b0;
         r_pe_match <= 1'b0;
         r_valid    <= 1'b0;

         case (r_state)
            StIdle: begin
               if (UARTstart) begin
                  r_state    <= StWaitRam;
                  r_busy     <= 1'b1;
                  r_pe_reset <= 1'b1;
                  r_best_sad <= '1;
                  r_cand_x   <= '0;
                  r_cand_y   <= '0;
                  r_x_out    <= '0;
                  r_y_out    <= '0;
                  r_rom_addr <= '0;
               end
            end

            StWaitRam: begin
               if (RAMready) begin
                  r_state    <= StLoadTpl;
                  r_rom_addr <= '0;
                  r_pe_load  <= 1'b1;
               end
            end

            StLoadTpl: begin
               if (r_rom_addr == LAST_ROM) begin
                  r_state    <= StScanReq;
                  r_pe_load  <= 1'b0;
                  r_pe_match <= 1'b1;
               end else begin
                  r_rom_addr <= r_rom_addr + ROM_AW'(1);
               end
            end

            StScanReq: begin
               r_state <= StScanWait;
            end

            StScanWait: begin
               if (sad_valid) begin
                  if (w_better) begin
                     r_best_sad <= sad_in;
                     r_x_out    <= r_cand_x;
                     r_y_out    <= r_cand_y;
                  end
                  if (w_last || w_exit) begin
                     r_state     <= StSendX;
                     r_uart_send <= UART_X;
                  end else begin
                     // Raster advance; PEshift and the next PEmatch share the
                     // first SCAN_REQ cycle of the new candidate.
                     if (r_cand_x == LAST_X) begin
                        r_cand_x <= '0;
                        r_cand_y <= r_cand_y + Y_W'(1);
                     end else begin
                        r_cand_x <= r_cand_x + X_W'(1);
                     end
                     r_pe_shift <= 1'b1;
                     r_pe_match <= 1'b1;
                     r_state    <= StScanReq;
                  end
               end
            end

            StSendX: begin
               if (UARTsendComplete) begin
                  r_state     <= StSendY;
                  r_uart_send <= UART_Y;
               end
            end

            StSendY: begin
               if (UARTsendComplete) begin
                  r_state     <= StDone;
                  r_uart_send <= UART_IDLE;
                  r_valid     <= 1'b1;
               end
            end

            StDone: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign PEreset   = r_pe_reset;
   assign PEload    = r_pe_load;
   assign PEshift   = r_pe_shift;
   assign PEmatch   = r_pe_match;
   assign ROMtoRead = r_rom_addr;
   assign cand_x    = r_cand_x;
   assign cand_y    = r_cand_y;
   assign UARTsend  = r_uart_send;
   assign busy      = r_busy;
   assign valid     = r_valid;
   assign x_out     = r_x_out;
   assign y_out     = r_y_out;
   assign best_sad  = r_best_sad;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl on an 8x6 image with a 4x4 template
// (5 x 3 = 15 candidates). Two instances share control inputs: dut A has
// EARLY_EXIT=0, dut B has EARLY_EXIT=1. Each has its own PE-array responder
// that returns a SAD from a table indexed by the candidate position.
module tb_sad_search_ctrl;

   localparam int unsigned IMG_W = 8;
   localparam int unsigned IMG_H = 6;
   localparam int unsigned TPL   = 4;
   localparam int unsigned SAD_W = 16;
   localparam int unsigned X_W   = 10;
   localparam int unsigned Y_W   = 9;
   localparam int unsigned NCX   = IMG_W - TPL + 1;
   localparam int unsigned NCAND = NCX * (IMG_H - TPL + 1);

   logic             clock = 1'b0;
   logic             reset;
   logic             UARTstart;
   logic             RAMready;
   logic             UARTsendComplete;
   logic [SAD_W-1:0] threshold;

   logic [SAD_W-1:0] a_sad_in, b_sad_in;
   logic             a_sad_valid, b_sad_valid;
   logic             a_PEreset, a_PEload, a_PEshift, a_PEmatch, a_busy, a_valid;
   logic             b_PEreset, b_PEload, b_PEshift, b_PEmatch, b_busy, b_valid;
   logic [3:0]       a_ROMtoRead, b_ROMtoRead;
   logic [X_W-1:0]   a_cand_x, b_cand_x, a_x_out, b_x_out;
   logic [Y_W-1:0]   a_cand_y, b_cand_y, a_y_out, b_y_out;
   logic [1:0]       a_UARTsend, b_UARTsend;
   logic [SAD_W-1:0] a_best_sad, b_best_sad;

   logic [SAD_W-1:0] tbl [NCAND];

   int n_chk  = 0;
   int n_fail = 0;
   int load_cnt_a, rom_bad_a, shift_cnt_a, match_cnt_a, match_cnt_b;

   always #5 clock = ~clock;

   sad_search_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .TPL(TPL), .SAD_W(SAD_W),
      .X_W(X_W), .Y_W(Y_W), .EARLY_EXIT(0)
   ) u_dut_a (
      .clock(clock), .reset(reset), .UARTstart(UARTstart), .RAMready(RAMready),
      .UARTsendComplete(UARTsendComplete), .sad_in(a_sad_in), .sad_valid(a_sad_valid),
      .threshold(threshold), .PEreset(a_PEreset), .PEload(a_PEload), .PEshift(a_PEshift),
      .PEmatch(a_PEmatch), .ROMtoRead(a_ROMtoRead), .cand_x(a_cand_x), .cand_y(a_cand_y),
      .UARTsend(a_UARTsend), .busy(a_busy), .valid(a_valid), .x_out(a_x_out),
      .y_out(a_y_out), .best_sad(a_best_sad)
   );

   sad_search_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .TPL(TPL), .SAD_W(SAD_W),
      .X_W(X_W), .Y_W(Y_W), .EARLY_EXIT(1)
   ) u_dut_b (
      .clock(clock), .reset(reset), .UARTstart(UARTstart), .RAMready(RAMready),
      .UARTsendComplete(UARTsendComplete), .sad_in(b_sad_in), .sad_valid(b_sad_valid),
      .threshold(threshold), .PEreset(b_PEreset), .PEload(b_PEload), .PEshift(b_PEshift),
      .PEmatch(b_PEmatch), .ROMtoRead(b_ROMtoRead), .cand_x(b_cand_x), .cand_y(b_cand_y),
      .UARTsend(b_UARTsend), .busy(b_busy), .valid(b_valid), .x_out(b_x_out),
      .y_out(b_y_out), .best_sad(b_best_sad)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // PE array model for dut A: two cycles after a PEmatch, return the table SAD.
   initial begin
      a_sad_in = '0;
      a_sad_valid = 1'b0;
      forever begin
         @(negedge clock);
         a_sad_valid = 1'b0;
         if (a_PEmatch) begin
            int idx;
            idx = int'(a_cand_y) * NCX + int'(a_cand_x);
            match_cnt_a++;
            repeat (2) @(negedge clock);
            a_sad_in = (idx < NCAND) ? tbl[idx] : 16'hFFFF;
            a_sad_valid = 1'b1;
         end
      end
   end

   initial begin
      b_sad_in = '0;
      b_sad_valid = 1'b0;
      forever begin
         @(negedge clock);
         b_sad_valid = 1'b0;
         if (b_PEmatch) begin
            int idx;
            idx = int'(b_cand_y) * NCX + int'(b_cand_x);
            match_cnt_b++;
            repeat (2) @(negedge clock);
            b_sad_in = (idx < NCAND) ? tbl[idx] : 16'hFFFF;
            b_sad_valid = 1'b1;
         end
      end
   end

   // Template-load and shift monitor for dut A.
   initial begin
      forever begin
         @(negedge clock);
         if (a_PEload) begin
            if (int'(a_ROMtoRead) != load_cnt_a) rom_bad_a++;
            load_cnt_a++;
         end
         if (a_PEshift) shift_cnt_a++;
      end
   end

   task automatic fill_tbl(input logic [SAD_W-1:0] dflt);
      for (int i = 0; i < NCAND; i++) tbl[i] = dflt;
   endtask

   task automatic clear_counts();
      load_cnt_a  = 0;
      rom_bad_a   = 0;
      shift_cnt_a = 0;
      match_cnt_a = 0;
      match_cnt_b = 0;
   endtask

   // Start a search and release RAMready; returns with dut A in LOAD_TPL.
   task automatic start_search(input string tag);
      @(negedge clock);
      clear_counts();
      UARTstart = 1'b1;
      @(negedge clock);
      UARTstart = 1'b0;
      check_eq({tag, "_pereset_first"}, {31'd0, a_PEreset}, 1);
      check_eq({tag, "_busy"}, {31'd0, a_busy}, 1);
      check_eq({tag, "_best_init"}, {16'd0, a_best_sad}, 32'hFFFF);
      @(negedge clock);
      check_eq({tag, "_pereset_once"}, {31'd0, a_PEreset}, 0);
      check_eq({tag, "_waitram_noload"}, {31'd0, a_PEload}, 0);
      RAMready = 1'b1;
      @(negedge clock);
      RAMready = 1'b0;
      check_eq({tag, "_load_start"}, {31'd0, a_PEload}, 1);
   endtask

   function automatic logic [1:0] usend(input int k);
      return (k == 0) ? a_UARTsend : b_UARTsend;
   endfunction

   // Wait for SEND_X on dut k, complete both words, check the result strobe.
   task automatic finish_send(input string tag, input int k, input int ex, input int ey,
                              input int esad, input int hold);
      int n;
      n = 0;
      while (usend(k) != 2'b01 && n < 1000) begin
         @(negedge clock);
         n++;
      end
      check_eq({tag, "_reach_send_x"}, {30'd0, usend(k)}, 1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         check_eq({tag, "_hold_send_x"}, {30'd0, usend(k)}, 1);
         check_eq({tag, "_hold_novalid"}, {31'd0, (k == 0) ? a_valid : b_valid}, 0);
      end
      UARTsendComplete = 1'b1;
      @(negedge clock);
      check_eq({tag, "_send_y"}, {30'd0, usend(k)}, 2);
      @(negedge clock);
      UARTsendComplete = 1'b0;
      check_eq({tag, "_valid"}, {31'd0, (k == 0) ? a_valid : b_valid}, 1);
      check_eq({tag, "_x"}, 32'((k == 0) ? a_x_out : b_x_out), ex);
      check_eq({tag, "_y"}, 32'((k == 0) ? a_y_out : b_y_out), ey);
      check_eq({tag, "_sad"}, 32'((k == 0) ? a_best_sad : b_best_sad), esad);
      @(negedge clock);
      check_eq({tag, "_valid_pulse"}, {31'd0, (k == 0) ? a_valid : b_valid}, 0);
      check_eq({tag, "_idle"}, {31'd0, (k == 0) ? a_busy : b_busy}, 0);
      check_eq({tag, "_uart_idle"}, {30'd0, usend(k)}, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"}, {31'd0, a_busy}, 0);
      check_eq({tag, "_valid"}, {31'd0, a_valid}, 0);
      check_eq({tag, "_pe"}, {28'd0, a_PEreset, a_PEload, a_PEshift, a_PEmatch}, 0);
      check_eq({tag, "_rom"}, {28'd0, a_ROMtoRead}, 0);
      check_eq({tag, "_cand"}, {13'd0, a_cand_y, a_cand_x}, 0);
      check_eq({tag, "_xy"}, {13'd0, a_y_out, a_x_out}, 0);
      check_eq({tag, "_uart"}, {30'd0, a_UARTsend}, 0);
      check_eq({tag, "_best"}, {16'd0, a_best_sad}, 32'hFFFF);
      check_eq({tag, "_b_best"}, {16'd0, b_best_sad}, 32'hFFFF);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      UARTstart = 1'b0;
      RAMready = 1'b0;
      UARTsendComplete = 1'b0;
      threshold = '0;
      clear_counts();
      fill_tbl(16'd100);
      repeat (3) @(negedge clock);
      check_reset_outputs("rst");
      reset = 1'b0;

      // 1) single minimum at (3,1); UART held off for 20 cycles in SEND_X
      fill_tbl(16'd100);
      tbl[1*NCX + 3] = 16'd7;
      start_search("t1");
      @(negedge clock);
      UARTstart = 1'b1;   // must be ignored mid-search
      @(negedge clock);
      UARTstart = 1'b0;
      check_eq("t1_start_ignored", {31'd0, a_PEreset}, 0);
      finish_send("t1", 0, 3, 1, 7, 20);
      check_eq("t1_loads", load_cnt_a, 16);
      check_eq("t1_rom_seq_errs", rom_bad_a, 0);
      check_eq("t1_matches", match_cnt_a, 15);
      check_eq("t1_shifts", shift_cnt_a, 14);
      check_eq("t1_last_cand", {13'd0, a_cand_y, a_cand_x}, {13'd0, 9'd2, 10'd4});
      check_eq("t1_b_x", 32'(b_x_out), 3);
      check_eq("t1_b_sad", 32'(b_best_sad), 7);
      repeat (3) @(negedge clock);
      check_eq("t1_hold_x", 32'(a_x_out), 3);
      check_eq("t1_hold_sad", 32'(a_best_sad), 7);

      // 2) tie: SAD 5 at (1,0) and (2,2) keeps the first
      fill_tbl(16'd100);
      tbl[0*NCX + 1] = 16'd5;
      tbl[2*NCX + 2] = 16'd5;
      start_search("t2");
      finish_send("t2", 0, 1, 0, 5, 0);
      check_eq("t2_b_y", 32'(b_y_out), 0);
      check_eq("t2_b_x", 32'(b_x_out), 1);

      // 3) early exit on dut B at (2,0); dut A scans everything
      fill_tbl(16'd100);
      tbl[0*NCX + 2] = 16'd9;
      threshold = 16'd10;
      start_search("t3");
      finish_send("t3b", 1, 2, 0, 9, 0);
      check_eq("t3_b_matches", match_cnt_b, 3);
      finish_send("t3a", 0, 2, 0, 9, 0);
      check_eq("t3_a_matches", match_cnt_a, 15);
      check_eq("t3_b_matches_final", match_cnt_b, 3);
      threshold = '0;

      // 4) reset in SCAN_WAIT, then a fresh search with the best at the last candidate
      fill_tbl(16'd100);
      tbl[0] = 16'd2;
      start_search("t4");
      n = 0;
      while (match_cnt_a < 5 && n < 500) begin
         @(negedge clock);
         n++;
      end
      check_eq("t4_reach_scan", match_cnt_a, 5);
      @(negedge clock);
      check_eq("t4_in_scan_wait", {30'd0, a_busy, a_PEmatch}, 2);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("t4_async");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      check_reset_outputs("t4_after");
      fill_tbl(16'd100);
      tbl[2*NCX + 4] = 16'd3;
      start_search("t4r");
      finish_send("t4r", 0, 4, 2, 3, 0);
      check_eq("t4r_matches", match_cnt_a, 15);
      check_eq("t4r_loads", load_cnt_a, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sad_search_ctrl.md
SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- IMG_W, 640, search image width in pixels.
- IMG_H, 480, search image height in pixels.
- TPL, 8, template side length; template is TPL x TPL.
- SAD_W, 16, SAD value width.
- X_W, 10, x coordinate width.
- Y_W, 9, y coordinate width.
- EARLY_EXIT, 0, 1 enables the threshold stop.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- UARTstart, in, 1, start search.
- RAMready, in, 1, image RAM loaded.
- UARTsendComplete, in, 1, current UART word sent.
- sad_in, in, SAD_W, SAD from PE array.
- sad_valid, in, 1, sad_in valid.
- threshold, in, SAD_W, early-exit limit.
- PEreset, out, 1, clear PE array.
- PEload, out, 1, template word load strobe.
- PEshift, out, 1, advance window one position.
- PEmatch, out, 1, request SAD of current window.
- ROMtoRead, out, clog2(TPL*TPL), template ROM address.
- cand_x, out, X_W, current candidate x.
- cand_y, out, Y_W, current candidate y.
- UARTsend, out, 2, 00 idle, 01 send x, 10 send y.
- busy, out, 1, high in every state except IDLE.
- valid, out, 1, one-cycle result strobe.
- x_out, out, X_W, best match x.
- y_out, out, Y_W, best match y.
- best_sad, out, SAD_W, best SAD found.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have these states: IDLE, WAIT_RAM, LOAD_TPL, SCAN_REQ, SCAN_WAIT, SEND_X, SEND_Y, DONE.
REQ-005 IDLE: UARTstart=1 SHALL go to WAIT_RAM; PEreset SHALL be high for exactly the first WAIT_RAM cycle; best_sad SHALL be set to all-ones and cand_x/cand_y to 0.
REQ-006 WAIT_RAM: RAMready=1 SHALL go to LOAD_TPL with ROMtoRead=0.
REQ-007 LOAD_TPL: PEload SHALL be high every cycle; ROMtoRead SHALL step 0..TPL*TPL-1, one per cycle; after the last address the FSM SHALL go to SCAN_REQ.
REQ-008 SCAN_REQ: PEmatch SHALL be high for one cycle, then the FSM SHALL go to SCAN_WAIT.
REQ-009 SCAN_WAIT: the FSM SHALL hold until sad_valid=1.
REQ-010 On accepting a SAD, if sad_in < best_sad, then best_sad, x_out and y_out SHALL take sad_in, cand_x and cand_y; a tie SHALL keep the earlier (first-found) position.
REQ-011 Candidate order SHALL be raster: x from 0 to IMG_W-TPL; at the end of a row x SHALL wrap to 0 and y SHALL increment; the last candidate is (IMG_W-TPL, IMG_H-TPL).
REQ-012 After accepting a SAD that is neither the last candidate nor an early exit, the FSM SHALL advance the candidate, pulse PEshift for one cycle and return to SCAN_REQ.
REQ-013 After the last candidate, or when EARLY_EXIT=1 and sad_in <= threshold (best updated first), the FSM SHALL go to SEND_X.
REQ-014 SEND_X SHALL drive UARTsend=01 until UARTsendComplete=1, then go to SEND_Y; SEND_Y SHALL drive 10 until UARTsendComplete=1, then go to DONE.
REQ-015 DONE SHALL pulse valid for one cycle and return to IDLE; x_out, y_out and best_sad SHALL hold until the next start.
REQ-016 The FSM SHALL ignore UARTstart outside IDLE, sad_valid outside SCAN_WAIT, and UARTsendComplete outside the SEND states.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 Reset SHALL return the FSM to IDLE immediately from any state, including mid-scan or mid-send.
REQ-019 During and after reset, all outputs SHALL be 0 except best_sad, which SHALL be all-ones.

Verification (IMG_W=8, IMG_H=6, TPL=4, i.e. 15 candidates)
REQ-020 Bench: start, RAMready, then exactly 16 PEload cycles (ROMtoRead 0..15), then PEmatch once per candidate.
REQ-021 Bench: sad_in = 100 everywhere except 7 at (3,1) -> UARTsend 01, then 10; valid pulse with x_out=3, y_out=1, best_sad=7.
REQ-022 Bench: SAD 5 at both (1,0) and (2,2) -> result (1,0); check the tie rule.
REQ-023 Bench: EARLY_EXIT=1, threshold=10, SAD 9 at (2,0) -> no PEmatch after that candidate; result (2,0).
REQ-024 Bench: reset asserted while in SCAN_WAIT -> asynchronous return to IDLE with outputs at reset values; a fresh start then completes normally.
REQ-025 Bench: UARTsendComplete held low for 20 cycles -> UARTsend stays 01 and valid stays 0.
